// File: rtl/rsa_rng_pkg.sv
// Shared types and helpers for the LFSR random-word source on the RSA prime-candidate path.
// The step function works at the widest supported width; narrower users zero-extend and truncate.
package rsa_rng_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        VALID = 2'd2
    } rng_state_e;

    localparam int LFSR_MAX_W = 512;

    localparam logic [LFSR_MAX_W-1:0] TAPS_512 =
        (512'd1 << 511) | (512'd1 << 509) | (512'd1 << 506) | (512'd1 << 503);

    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return {state[LFSR_MAX_W-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_multistep.sv
// Combinational chain of STEP_BITS single LFSR steps, so one clock edge advances STEP_BITS steps.
module lfsr_multistep
    import rsa_rng_pkg::*;
#(
    parameter int                    WORD_WIDTH = 512,
    parameter int                    STEP_BITS  = 8,
    parameter logic [WORD_WIDTH-1:0] TAPS       = WORD_WIDTH'(TAPS_512)
) (
    input  logic [WORD_WIDTH-1:0] i_state,
    output logic [WORD_WIDTH-1:0] o_state
);

    logic [STEP_BITS:0][WORD_WIDTH-1:0] w_chain;

    assign w_chain[0] = i_state;

    // Zero-extension keeps the upper bits out of the feedback; truncation drops the shifted-out MSB.
    for (genvar k = 0; k < STEP_BITS; k++) begin : g_step
        assign w_chain[k+1] = WORD_WIDTH'(lfsr_step(LFSR_MAX_W'(w_chain[k]), LFSR_MAX_W'(TAPS)));
    end

    assign o_state = w_chain[STEP_BITS];

endmodule

// File: rtl/lfsr_rand_gen.sv
// LFSR random-word source: fills the whole state between words, then presents a conditioned word
// under a valid/ready handshake. Seeding and all-zero lock-up recovery act on the stored state.
module lfsr_rand_gen
    import rsa_rng_pkg::*;
#(
    parameter int                    WORD_WIDTH = 512,
    parameter int                    STEP_BITS  = 8,
    parameter logic [WORD_WIDTH-1:0] TAPS       = WORD_WIDTH'(TAPS_512),
    parameter bit                    FORCE_MSB  = 1'b1,
    parameter bit                    FORCE_ODD  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_valid,
    input  logic [WORD_WIDTH-1:0] seed,
    input  logic                  req,
    output logic                  rand_valid,
    input  logic                  rand_ready,
    output logic [WORD_WIDTH-1:0] rand_out,
    output logic                  lockup
);

    localparam int FILL_CYCLES = (WORD_WIDTH + STEP_BITS - 1) / STEP_BITS;
    localparam int CNT_W       = $clog2(FILL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FILL_CYCLES - 1);

    if (WORD_WIDTH < 8 || WORD_WIDTH > LFSR_MAX_W) begin : g_bad_width
        $error("lfsr_rand_gen: WORD_WIDTH out of range");
    end
    if (STEP_BITS < 1 || STEP_BITS > WORD_WIDTH) begin : g_bad_step
        $error("lfsr_rand_gen: STEP_BITS out of range");
    end
    if (TAPS[WORD_WIDTH-1] == 1'b0) begin : g_bad_taps
        $error("lfsr_rand_gen: TAPS MSB must be set");
    end

    rng_state_e             r_fsm, w_fsm_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [WORD_WIDTH-1:0]  r_lfsr, w_lfsr_nxt;
    logic [WORD_WIDTH-1:0]  r_out, w_out_nxt;
    logic                   r_valid, w_valid_nxt;
    logic                   r_lockup, w_lockup_nxt;
    logic [WORD_WIDTH-1:0]  w_stepped, w_cond, w_cand;
    logic                   w_load;

    lfsr_multistep #(
        .WORD_WIDTH (WORD_WIDTH),
        .STEP_BITS  (STEP_BITS),
        .TAPS       (TAPS)
    ) u_step (
        .i_state (r_lfsr),
        .o_state (w_stepped)
    );

    // Conditioning only shapes the presented word; the LFSR state keeps its raw bits.
    always_comb begin
        w_cond = w_stepped;
        if (FORCE_MSB) w_cond[WORD_WIDTH-1] = 1'b1;
        if (FORCE_ODD) w_cond[0] = 1'b1;
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_valid_nxt = r_valid;
        w_cand      = r_lfsr;
        w_load      = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (req) begin
                    w_fsm_nxt = FILL;
                    w_cnt_nxt = CNT_RELOAD;
                end
            end
            FILL: begin
                w_load = 1'b1;
                w_cand = w_stepped;
                if (r_cnt == '0) begin
                    w_out_nxt   = w_cond;
                    w_valid_nxt = 1'b1;
                    w_fsm_nxt   = VALID;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            VALID: begin
                if (r_valid && rand_ready) begin
                    w_valid_nxt = 1'b0;
                    if (req) begin
                        w_fsm_nxt = FILL;
                        w_cnt_nxt = CNT_RELOAD;
                    end else begin
                        w_fsm_nxt = IDLE;
                    end
                end
            end
            default: w_fsm_nxt = IDLE;
        endcase

        // A seed mid-fill discards the partial word and restarts the fill from the seed.
        if (seed_valid) begin
            w_load = 1'b1;
            w_cand = seed;
            if (r_fsm == FILL) begin
                w_fsm_nxt   = FILL;
                w_cnt_nxt   = CNT_RELOAD;
                w_out_nxt   = r_out;
                w_valid_nxt = r_valid;
            end
        end

        w_lockup_nxt = w_load && (w_cand == '0);
        w_lfsr_nxt   = w_lockup_nxt ? '1 : w_cand;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm    <= IDLE;
            r_cnt    <= '0;
            r_lfsr   <= '1;
            r_out    <= '0;
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_fsm    <= w_fsm_nxt;
            r_cnt    <= w_cnt_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_out    <= w_out_nxt;
            r_valid  <= w_valid_nxt;
            r_lockup <= w_lockup_nxt;
        end
    end

    assign rand_valid = r_valid;
    assign rand_out   = r_out;
    assign lockup     = r_lockup;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench: three 8-bit instances share stimulus (1-step conditioned, 1-step raw, 4-step),
// plus a full-width default instance checked against a 512-step reference model.
module tb_lfsr_rand_gen;

    logic       clk = 1'b0;
    logic       rst, seed_valid, req, rand_ready;
    logic [7:0] seed;
    logic       v_a, v_b, v_c, lk_a, lk_b, lk_c;
    logic [7:0] o_a, o_b, o_c;

    logic         w_rst, w_req;
    logic         v_w, lk_w;
    logic [511:0] o_w;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lfsr_rand_gen #(.WORD_WIDTH(8), .STEP_BITS(1), .TAPS(8'hB8), .FORCE_MSB(1'b1), .FORCE_ODD(1'b1)) u_a (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed), .req(req),
        .rand_valid(v_a), .rand_ready(rand_ready), .rand_out(o_a), .lockup(lk_a));

    lfsr_rand_gen #(.WORD_WIDTH(8), .STEP_BITS(1), .TAPS(8'hB8), .FORCE_MSB(1'b0), .FORCE_ODD(1'b0)) u_b (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed), .req(req),
        .rand_valid(v_b), .rand_ready(rand_ready), .rand_out(o_b), .lockup(lk_b));

    lfsr_rand_gen #(.WORD_WIDTH(8), .STEP_BITS(4), .TAPS(8'hB8), .FORCE_MSB(1'b1), .FORCE_ODD(1'b1)) u_c (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed), .req(req),
        .rand_valid(v_c), .rand_ready(rand_ready), .rand_out(o_c), .lockup(lk_c));

    lfsr_rand_gen u_w (
        .clk(clk), .rst(w_rst), .seed_valid(1'b0), .seed(512'd0), .req(w_req),
        .rand_valid(v_w), .rand_ready(1'b0), .rand_out(o_w), .lockup(lk_w));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; seed_valid = 1'b0; seed = 8'h00; req = 1'b0; rand_ready = 1'b0;
        #1;
        n_vec++;
        if ({v_a, v_b, v_c} !== 3'b000) begin
            n_err++; $display("FAIL reset_valid got=%b exp=000", {v_a, v_b, v_c});
        end
        n_vec++;
        if ({o_a, o_b, o_c} !== 24'h0) begin
            n_err++; $display("FAIL reset_out got=%h exp=000000", {o_a, o_b, o_c});
        end
        n_vec++;
        if ({lk_a, lk_b, lk_c} !== 3'b000) begin
            n_err++; $display("FAIL reset_lockup got=%b exp=000", {lk_a, lk_b, lk_c});
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic_fill();
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 2) begin
                n_vec++;
                if (v_c !== 1'b1 || o_c !== 8'h8B) begin
                    n_err++; $display("FAIL step4_word got=%b/%h exp=1/8b", v_c, o_c);
                end
            end
            if (i == 7) begin
                n_vec++;
                if (v_a !== 1'b0) begin
                    n_err++; $display("FAIL step1_early_valid got=%b exp=0", v_a);
                end
            end
        end
        n_vec++;
        if (v_a !== 1'b1 || o_a !== 8'h8B) begin
            n_err++; $display("FAIL step1_cond_word got=%b/%h exp=1/8b", v_a, o_a);
        end
        n_vec++;
        if (v_b !== 1'b1 || o_b !== 8'h0B) begin
            n_err++; $display("FAIL step1_raw_word got=%b/%h exp=1/0b", v_b, o_b);
        end
    endtask

    task automatic test_seed_lockup();
        do_reset();
        seed = 8'h01; seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        n_vec++;
        if ({lk_a, lk_b, lk_c} !== 3'b000) begin
            n_err++; $display("FAIL seed01_lockup got=%b exp=000", {lk_a, lk_b, lk_c});
        end
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (8) tick();
        n_vec++;
        if (v_a !== 1'b1 || o_a !== 8'h9D) begin
            n_err++; $display("FAIL seed01_cond got=%b/%h exp=1/9d", v_a, o_a);
        end
        n_vec++;
        if (o_b !== 8'h1C || o_c !== 8'h9D) begin
            n_err++; $display("FAIL seed01_raw_step4 got=%h/%h exp=1c/9d", o_b, o_c);
        end
        rand_ready = 1'b1;
        tick();
        rand_ready = 1'b0;
        n_vec++;
        if ({v_a, v_b, v_c} !== 3'b000) begin
            n_err++; $display("FAIL handshake_to_idle got=%b exp=000", {v_a, v_b, v_c});
        end
        seed = 8'h00; seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        n_vec++;
        if ({lk_a, lk_b, lk_c} !== 3'b111) begin
            n_err++; $display("FAIL seed00_lockup_pulse got=%b exp=111", {lk_a, lk_b, lk_c});
        end
        tick();
        n_vec++;
        if ({lk_a, lk_b, lk_c} !== 3'b000) begin
            n_err++; $display("FAIL seed00_lockup_end got=%b exp=000", {lk_a, lk_b, lk_c});
        end
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (8) tick();
        n_vec++;
        if (o_a !== 8'h8B || o_b !== 8'h0B) begin
            n_err++; $display("FAIL after_lockup_word got=%h/%h exp=8b/0b", o_a, o_b);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if (v_a !== 1'b1 || o_a !== 8'h8B || o_b !== 8'h0B) begin
                n_err++; $display("FAIL backpressure_hold[%0d] got=%b/%h/%h exp=1/8b/0b", i, v_a, o_a, o_b);
            end
        end
        rand_ready = 1'b1; req = 1'b1;
        tick();
        rand_ready = 1'b0; req = 1'b0;
        n_vec++;
        if (v_a !== 1'b0 || v_b !== 1'b0) begin
            n_err++; $display("FAIL handshake_drop got=%b%b exp=00", v_a, v_b);
        end
        repeat (7) tick();
        n_vec++;
        if (v_a !== 1'b0) begin
            n_err++; $display("FAIL refill_early got=%b exp=0", v_a);
        end
        tick();
        n_vec++;
        if (v_a !== 1'b1 || o_a !== 8'hC7 || o_b !== 8'hC6) begin
            n_err++; $display("FAIL refill_word got=%b/%h/%h exp=1/c7/c6", v_a, o_a, o_b);
        end
        n_vec++;
        if (v_c !== 1'b1 || o_c !== 8'hC7) begin
            n_err++; $display("FAIL refill_step4 got=%b/%h exp=1/c7", v_c, o_c);
        end
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if (v_a !== 1'b0 || o_a !== 8'h00 || v_c !== 1'b0 || o_c !== 8'h00) begin
            n_err++; $display("FAIL midfill_reset got=%b/%h %b/%h exp=0/00 0/00", v_a, o_a, v_c, o_c);
        end
        tick();
        rst = 1'b0;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (8) tick();
        n_vec++;
        if (v_a !== 1'b1 || o_a !== 8'h8B) begin
            n_err++; $display("FAIL post_reset_word got=%b/%h exp=1/8b", v_a, o_a);
        end
    endtask

    task automatic test_full_width();
        logic [511:0] taps, ref_s, exp_w;
        taps = '0;
        taps[511] = 1'b1; taps[509] = 1'b1; taps[506] = 1'b1; taps[503] = 1'b1;
        ref_s = '1;
        for (int i = 0; i < 512; i++) ref_s = {ref_s[510:0], ^(ref_s & taps)};
        exp_w = ref_s;
        exp_w[511] = 1'b1;
        exp_w[0] = 1'b1;
        w_rst = 1'b1; w_req = 1'b0;
        tick();
        w_rst = 1'b0;
        w_req = 1'b1;
        tick();
        w_req = 1'b0;
        repeat (63) tick();
        n_vec++;
        if (v_w !== 1'b0) begin
            n_err++; $display("FAIL w512_early got=%b exp=0", v_w);
        end
        tick();
        n_vec++;
        if (v_w !== 1'b1 || o_w !== exp_w) begin
            n_err++; $display("FAIL w512_word valid=%b got=%h exp=%h", v_w, o_w[63:0], exp_w[63:0]);
        end
        n_vec++;
        if (o_w[511] !== 1'b1 || o_w[0] !== 1'b1) begin
            n_err++; $display("FAIL w512_cond_bits got=%b%b exp=11", o_w[511], o_w[0]);
        end
    endtask

    initial begin
        w_rst = 1'b1; w_req = 1'b0;
        test_reset();
        test_basic_fill();
        test_seed_lockup();
        test_back_to_back();
        test_reset_mid_fill();
        test_full_width();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
